// File: rtl/haraka_rc_streamer.sv
// Streams the 40 Haraka v2 128-bit round constants over a valid/ready link, tagged by round/word.
// Optional HARAKA_RC_AUTOLOOP_EN: restart at beat 0 after the last beat instead of returning to idle.
module haraka_rc_streamer #(
  parameter int NROUNDS = 5,
  parameter int RC_W    = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            rc_ready,
  output logic            rc_valid,
  output logic [RC_W-1:0] rc_data,
  output logic [2:0]      rc_round,
  output logic [2:0]      rc_word,
  output logic            rc_last_word,
  output logic            rc_last,
  output logic            busy,
  output logic            done
);

  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;
  localparam logic [5:0] K_LAST = 6'(NROUNDS * 8 - 1);

  logic       state_reg, state_next;
  logic [5:0] k_reg, k_next;
  logic       valid_next, done_next, handshake;

  function automatic logic [127:0] rc_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  rc_rom = 128'h0684704ce620c00ab2c5fef075817b9d;
      6'd1:  rc_rom = 128'h8b66b4e188f3a06b640f6ba42f08f717;
      6'd2:  rc_rom = 128'h3402de2d53f28498cf029d609f029114;
      6'd3:  rc_rom = 128'h0ed6eae62e7b4f08bbf3bcaffd5b4f79;
      6'd4:  rc_rom = 128'hcbcfb0cb4872448b79eecd1cbe397044;
      6'd5:  rc_rom = 128'h7eeacdee6e9032b78d5335ed2b8a057b;
      6'd6:  rc_rom = 128'h67c28f435e2e7cd0e2412761da4fef1b;
      6'd7:  rc_rom = 128'h2924d9b0afcacc07675ffde21fc70b3b;
      6'd8:  rc_rom = 128'hab4d63f1e6867fe9ecdb8fcab9d465ee;
      6'd9:  rc_rom = 128'h1c30bf84d4b7cd645b2a404fad037e33;
      6'd10: rc_rom = 128'hb2cc0bb9941723bf69028b2e8df69800;
      6'd11: rc_rom = 128'hfa0478a6de6f55724aaa9ec85c9d2d8a;
      6'd12: rc_rom = 128'hdfb49f2b6b772a120efa4f2e29129fd4;
      6'd13: rc_rom = 128'h1ea10344f449a23632d611aebb6a12ee;
      6'd14: rc_rom = 128'haf0449884b0500845f9600c99ca8eca6;
      6'd15: rc_rom = 128'h21025ed89d199c4f78a2c7e327e593ec;
      6'd16: rc_rom = 128'hbf3aaaf8a759c9b7b9282ecd82d40173;
      6'd17: rc_rom = 128'h6260700d6186b01737f2efd910307d6b;
      6'd18: rc_rom = 128'h5aca45c22130044381c29153f6fc9ac6;
      6'd19: rc_rom = 128'h9223973c226b68bb2caf92e836d1943a;
      6'd20: rc_rom = 128'hd3bf9238225886eb6cbab958e51071b4;
      6'd21: rc_rom = 128'hdb863ce5aef0c677933dfddd24e1128d;
      6'd22: rc_rom = 128'hbb606268ffeba09c83e48de3cb2212b1;
      6'd23: rc_rom = 128'h734bd3dce2e4d19c2db91a4ec72bf77d;
      6'd24: rc_rom = 128'h43bb47c361301b434b1415c42cb3924e;
      6'd25: rc_rom = 128'hdba775a8e707eff603b231dd16eb6899;
      6'd26: rc_rom = 128'h6df3614b3c7559778e5e23027eca472c;
      6'd27: rc_rom = 128'hcda75a17d6de7d776d1be5b9b88617f9;
      6'd28: rc_rom = 128'hec6b43f06ba8e9aa9d6c069da946ee5d;
      6'd29: rc_rom = 128'hcb1e6950f957332ba25311593bf327c1;
      6'd30: rc_rom = 128'h2cee0c7500da619ce4ed0353600ed0d9;
      6'd31: rc_rom = 128'hf0b1a5a196e90cab80bbbabc63a4a350;
      6'd32: rc_rom = 128'hae3db1025e962988ab0dde30938dca39;
      6'd33: rc_rom = 128'h17bb8f38d554a40b8814f3a82e75b442;
      6'd34: rc_rom = 128'h34bb8a5b5f427fd7aeb6b779360a16f6;
      6'd35: rc_rom = 128'h26f65241cbe5543843ce5918ffbaafde;
      6'd36: rc_rom = 128'h4ce99a54b9f3026aa2ca9cf7839ec978;
      6'd37: rc_rom = 128'hae51a51a1bdff7be40c06e2822901235;
      6'd38: rc_rom = 128'ha0c1613cba7ed22bc173bc0f48a659cf;
      6'd39: rc_rom = 128'h756acc03022882884ad6bdfde9c59da1;
      default: rc_rom = 128'h0;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    valid_next = rc_valid;
    done_next  = 1'b0;
    handshake  = rc_valid & rc_ready;
    case (state_reg)
      IDLE: begin
        // The done cycle is already IDLE, so a start there must be screened out explicitly.
        if (start && !abort && !done) begin
          state_next = STREAM;
          k_next     = '0;
          valid_next = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_next = IDLE;
          k_next     = '0;
          valid_next = 1'b0;
        end else if (handshake) begin
          if (k_reg == K_LAST) begin
            done_next = 1'b1;
`ifdef HARAKA_RC_AUTOLOOP_EN
            k_next    = '0;
`else
            state_next = IDLE;
            k_next     = '0;
            valid_next = 1'b0;
`endif
          end else begin
            k_next = k_reg + 6'd1;
          end
        end
      end
    endcase
  end

  // Beat payload is computed from the next index so every output is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      rc_valid     <= 1'b0;
      rc_data      <= '0;
      rc_round     <= '0;
      rc_word      <= '0;
      rc_last_word <= 1'b0;
      rc_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      rc_valid     <= valid_next;
      rc_data      <= valid_next ? rc_rom(k_next) : '0;
      rc_round     <= valid_next ? k_next[5:3] : 3'd0;
      rc_word      <= valid_next ? k_next[2:0] : 3'd0;
      rc_last_word <= valid_next && (k_next[2:0] == 3'd7);
      rc_last      <= valid_next && (k_next == K_LAST);
      busy         <= (state_next == STREAM);
      done         <= done_next;
    end
  end

endmodule
